// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the fetch-queue entry payload.
package cpu_types_pkg;

   localparam int unsigned CPU_WORD_W = 32;

   typedef logic [CPU_WORD_W-1:0] word_t;

   typedef struct packed {
      word_t instr;
      word_t pc;
      word_t pcplusfour;
   } fq_entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-to-decode queue bundle; fq is the queue side, tb drives fetch/decode.
interface ifetch_queue_if #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned WORD_W = 32
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic              enq_valid;
   logic              enq_ready;
   logic [WORD_W-1:0] instr_in;
   logic [WORD_W-1:0] pc_in;
   logic [WORD_W-1:0] pcplusfour_in;
   logic              deq_valid;
   logic              deq_ready;
   logic [WORD_W-1:0] instr_out;
   logic [WORD_W-1:0] pc_out;
   logic [WORD_W-1:0] pcplusfour_out;
   logic              flush;
   logic [CNT_W-1:0]  count;

   modport fq (
      input  enq_valid, instr_in, pc_in, pcplusfour_in, deq_ready, flush,
      output enq_ready, deq_valid, instr_out, pc_out, pcplusfour_out, count
   );

   modport tb (
      output enq_valid, instr_in, pc_in, pcplusfour_in, deq_ready, flush,
      input  enq_ready, deq_valid, instr_out, pc_out, pcplusfour_out, count
   );

endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: show-ahead FIFO between fetch and decode with
// flush on taken branch. Full/empty come from the registered count only.
module ifetch_queue
   import cpu_types_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned WORD_W = 32
) (
   input logic        CLK,
   input logic        RST,
   ifetch_queue_if.fq fqif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   fq_entry_t        mem [DEPTH];
   fq_entry_t        wr_entry;
   fq_entry_t        head_entry;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] cnt;
   logic             full;
   logic             empty;
   logic             enq_fire;
   logic             deq_fire;

   assign full     = (cnt == CNT_W'(DEPTH));
   assign empty    = (cnt == '0);
   assign enq_fire = fqif.enq_valid && !full && !fqif.flush;
   assign deq_fire = !empty && fqif.deq_ready && !fqif.flush;

   assign wr_entry = '{instr:      CPU_WORD_W'(fqif.instr_in),
                       pc:         CPU_WORD_W'(fqif.pc_in),
                       pcplusfour: CPU_WORD_W'(fqif.pcplusfour_in)};

   // Pointers and occupancy; flush wins over both fires.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else if (fqif.flush) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (enq_fire) tail <= tail + PTR_W'(1);
         if (deq_fire) head <= head + PTR_W'(1);
         case ({enq_fire, deq_fire})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage is never cleared; the empty mask keeps stale entries invisible.
   always_ff @(posedge CLK) begin
      if (enq_fire) mem[tail] <= wr_entry;
   end

   assign head_entry = mem[head];

   assign fqif.enq_ready      = !full;
   assign fqif.deq_valid      = !empty;
   assign fqif.count          = cnt;
   assign fqif.instr_out      = empty ? '0 : WORD_W'(head_entry.instr);
   assign fqif.pc_out         = empty ? '0 : WORD_W'(head_entry.pc);
   assign fqif.pcplusfour_out = empty ? '0 : WORD_W'(head_entry.pcplusfour);

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus random traffic
// scored against a queue-based reference model.
module tb_ifetch_queue;
   import cpu_types_pkg::*;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned WORD_W = 32;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   fq_entry_t model_q[$];

   ifetch_queue_if #(.DEPTH(DEPTH), .WORD_W(WORD_W)) fqif ();

   ifetch_queue #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
      .CLK  (clk),
      .RST  (rst),
      .fqif (fqif.fq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every output against what the model says the queue holds.
   task automatic check_state(input string tag);
      fq_entry_t h;
      h = '0;
      if (model_q.size() > 0) h = model_q[0];
      check({tag, ":count"},      64'(fqif.count),          64'(model_q.size()));
      check({tag, ":deq_valid"},  64'(fqif.deq_valid),      64'(model_q.size() > 0));
      check({tag, ":enq_ready"},  64'(fqif.enq_ready),      64'(model_q.size() < DEPTH));
      check({tag, ":instr"},      64'(fqif.instr_out),      64'(h.instr));
      check({tag, ":pc"},         64'(fqif.pc_out),         64'(h.pc));
      check({tag, ":pcplusfour"}, 64'(fqif.pcplusfour_out), 64'(h.pcplusfour));
   endtask

   task automatic drive(input logic ev, input logic dr, input logic fl, input fq_entry_t e);
      fqif.enq_valid     = ev;
      fqif.deq_ready     = dr;
      fqif.flush         = fl;
      fqif.instr_in      = e.instr;
      fqif.pc_in         = e.pc;
      fqif.pcplusfour_in = e.pcplusfour;
   endtask

   // One clock edge: advance the model from the pre-edge inputs, then check.
   task automatic step(input string tag);
      int unsigned n;
      logic        ef;
      logic        df;
      fq_entry_t   e;
      @(posedge clk);
      n  = model_q.size();
      ef = fqif.enq_valid && (n < DEPTH) && !fqif.flush;
      df = fqif.deq_ready && (n > 0) && !fqif.flush;
      e  = '{instr: fqif.instr_in, pc: fqif.pc_in, pcplusfour: fqif.pcplusfour_in};
      if (fqif.flush) begin
         model_q.delete();
      end else begin
         if (df) void'(model_q.pop_front());
         if (ef) model_q.push_back(e);
      end
      #1;
      check_state(tag);
   endtask

   function automatic fq_entry_t mk(input logic [31:0] instr, input logic [31:0] pc);
      return '{instr: instr, pc: pc, pcplusfour: pc + 32'd4};
   endfunction

   function automatic fq_entry_t rnd_entry();
      logic [31:0] pc;
      pc = $urandom & 32'hFFFF_FFFC;
      return mk($urandom, pc);
   endfunction

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, '0);
      repeat (2) @(posedge clk);
      #1;
      check_state("reset");

      // Release between edges, first edge afterwards must accept the enqueue.
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 1'b0, 1'b0, '{instr: 32'h2002_0001, pc: 32'h0, pcplusfour: 32'h4});
      step("first_enq");
      check("first_enq:instr_const", 64'(fqif.instr_out), 64'h2002_0001);
      check("first_enq:count_const", 64'(fqif.count), 64'd1);

      drive(1'b0, 1'b1, 1'b0, '0);
      step("drain_one");

      // Fill to full while decode stalls, then try a fifth entry.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 1'b0, mk(32'h1000_0000 + 32'(i), 32'h100 + 32'(4 * i)));
         step($sformatf("fill%0d", i));
      end
      check("full:count_const", 64'(fqif.count), 64'd4);
      check("full:enq_ready_const", 64'(fqif.enq_ready), 64'd0);
      drive(1'b1, 1'b0, 1'b0, mk(32'hDEAD_BEEF, 32'h200));
      step("fifth_ignored");
      check("fifth:head_const", 64'(fqif.instr_out), 64'h1000_0000);

      // Held head stays stable across stalled cycles.
      drive(1'b0, 1'b0, 1'b0, '0);
      step("stall_hold0");
      step("stall_hold1");

      // Full with both sides active: only the dequeue happens.
      drive(1'b1, 1'b1, 1'b0, mk(32'hCAFE_0000, 32'h300));
      step("full_enq_deq");
      check("full_enq_deq:count_const", 64'(fqif.count), 64'd3);
      check("full_enq_deq:enq_ready_const", 64'(fqif.enq_ready), 64'd1);

      // Down to two entries, then ten cycles of simultaneous traffic (wraps).
      drive(1'b0, 1'b1, 1'b0, '0);
      step("to_two");
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1, 1'b0, rnd_entry());
         step($sformatf("steady%0d", i));
      end
      check("steady:count_const", 64'(fqif.count), 64'd2);

      // Up to three, then flush racing an enqueue.
      drive(1'b1, 1'b0, 1'b0, rnd_entry());
      step("to_three");
      drive(1'b1, 1'b1, 1'b1, rnd_entry());
      step("flush_enq");
      check("flush:count_const", 64'(fqif.count), 64'd0);
      check("flush:deq_valid_const", 64'(fqif.deq_valid), 64'd0);
      check("flush:instr_const", 64'(fqif.instr_out), 64'd0);

      // Random traffic with occasional flushes.
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 50),
               1'($urandom_range(0, 99) < 4), rnd_entry());
         step("random");
      end

      // Two entries queued, then an asynchronous reset pulse between edges.
      drive(1'b0, 1'b0, 1'b1, '0);
      step("pre_rst_flush");
      drive(1'b1, 1'b0, 1'b0, mk(32'h5555_0001, 32'h40));
      step("pre_rst0");
      drive(1'b1, 1'b0, 1'b0, mk(32'h5555_0002, 32'h44));
      step("pre_rst1");
      drive(1'b0, 1'b0, 1'b0, '0);
      #2;
      rst = 1'b1;
      #1;
      model_q.delete();
      check_state("async_rst");
      check("async_rst:instr_const", 64'(fqif.instr_out), 64'd0);
      #1;
      rst = 1'b0;
      drive(1'b1, 1'b0, 1'b0, mk(32'h7777_0001, 32'h80));
      step("post_rst_enq");
      check("post_rst:instr_const", 64'(fqif.instr_out), 64'h7777_0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 4, number of queue entries (power of two, >= 2).
REQ-002 The block SHALL expose parameter WORD_W, default 32, width of the instr/pc/pcplusfour fields.
REQ-003 CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 enq_valid  input  1  fetch presents an entry this cycle.
REQ-006 instr_in, pc_in, pcplusfour_in  input  WORD_W each  entry payload from fetch.
REQ-007 enq_ready  output  1  queue accepts an entry; equals !full.
REQ-008 deq_valid  output  1  head entry is valid; equals !empty.
REQ-009 deq_ready  input  1  decode consumes head this cycle (deasserted on decode stall).
REQ-010 instr_out, pc_out, pcplusfour_out  output  WORD_W each  head entry payload.
REQ-011 flush  input  1  taken branch/jump; discard all queued entries.
REQ-012 count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-013 Enqueue fire = enq_valid && enq_ready && !flush; the payload SHALL be written at the tail and the tail pointer SHALL advance by one, modulo DEPTH.
REQ-014 Dequeue fire = deq_valid && deq_ready && !flush; the head pointer SHALL advance by one, modulo DEPTH.
REQ-015 Head outputs SHALL be show-ahead: driven combinationally from head storage, no added register stage.
REQ-016 When empty, instr_out, pc_out and pcplusfour_out SHALL be 0 (NOP bubble) and deq_valid SHALL be 0.
REQ-017 Latency SHALL be one cycle: an entry enqueued at edge N is visible on the outputs after edge N with deq_valid=1; there is no same-cycle bypass.
REQ-018 Simultaneous enqueue and dequeue fires SHALL leave count unchanged and advance both pointers.
REQ-019 When full, enq_ready SHALL be 0 even if deq_ready=1; there is no combinational path from deq_ready to enq_ready.
REQ-020 Flush SHALL take priority over enqueue and dequeue in the same cycle: after the edge, head=tail=0, count=0 and deq_valid=0.
REQ-021 count SHALL range 0..DEPTH, with full = (count==DEPTH) and empty = (count==0), both derived from registered state only.
REQ-022 Entry order SHALL be strictly FIFO, and pointer wrap SHALL NOT reorder or lose entries.
REQ-023 When deq_ready=0 and the queue is non-empty, the head outputs SHALL hold stable.

Reset
REQ-024 On RST assertion, asynchronously and regardless of CLK: head=0, tail=0, count=0, deq_valid=0, enq_ready=1, all payload outputs 0.
REQ-025 A reset asserted mid-operation SHALL discard all entries; storage contents need not be cleared but SHALL NOT be visible on the outputs.
REQ-026 On the first rising edge after RST deasserts, the block SHALL accept enqueues.

Structure
REQ-027 word_t and a packed struct fq_entry_t {instr, pc, pcplusfour} SHALL be declared in cpu_types_pkg.
REQ-028 Storage SHALL be an array of fq_entry_t indexed by $clog2(DEPTH)-bit pointers.
REQ-029 The block SHALL be a single module with no sub-module, since the storage is a register array inferred in place.
REQ-030 The block SHALL be accessed through an interface ifetch_queue_if with modports fq (block side) and tb.

Verification
REQ-031 Reset then enqueue instr=0x2002_0001, pc=0x0, pcplusfour=0x4 -> next cycle deq_valid=1, instr_out=0x2002_0001, count=1.
REQ-032 With DEPTH=4, enqueue 4 entries with deq_ready=0 -> count=4, enq_ready=0; a 5th enq_valid is ignored and the head is still the first entry.
REQ-033 Full queue, enq_valid=1, deq_ready=1 -> dequeue only, count=3, enq_ready=1 next cycle.
REQ-034 Count=2 with simultaneous enqueue and dequeue for 10 cycles -> count stays 2, pointers wrap, and output order matches input order.
REQ-035 Count=3 with flush=1 and enq_valid=1 in the same cycle -> count=0, deq_valid=0, instr_out=0 next cycle.
REQ-036 RST pulsed between edges while count=2 -> outputs zero immediately, count=0, enq_ready=1.
